// File: rtl/fp_add_arbiter.sv
// Time-shares one single-precision adder among NUM_REQ clients with a round-robin grant.
// Only one operation is in flight; its result is returned tagged with the owning requester.
module fp_add_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 2,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [NUM_REQ-1:0]     req_cmd,
  output logic [31:0]            add_number1,
  output logic [31:0]            add_number2,
  output logic                   add_command,
  input  logic                   add_sum1,
  input  logic [7:0]             add_sum2,
  input  logic [22:0]            add_sum3,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_data,
  output logic [ID_W-1:0]        resp_id,
  output logic                   busy
);

  localparam int CNT_W  = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
  localparam int CAND_W = ID_W + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LATENCY - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       add_a_q, add_a_d;
  logic [31:0]       add_b_q, add_b_d;
  logic              add_cmd_q, add_cmd_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [CAND_W-1:0] cand;

  // Search from the pointer upward, wrapping at NUM_REQ rather than at the power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = CAND_W'(ptr_q) + CAND_W'(i);
      if (cand >= CAND_W'(NUM_REQ)) begin
        cand = cand - CAND_W'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    add_cmd_d    = add_cmd_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    req_ready    = '0;

    case (state_q)
      IDLE: begin
        if (grant_found && rst_n) begin
          req_ready = NUM_REQ'(1) << grant_idx;
          add_a_d   = req_a[{grant_idx, 5'd0} +: 32];
          add_b_d   = req_b[{grant_idx, 5'd0} +: 32];
          add_cmd_d = req_cmd[grant_idx];
          resp_id_d = grant_idx;
          cnt_d     = CNT_LOAD;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          resp_data_d  = {add_sum1, add_sum2, add_sum3};
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        // The next search starts just past the requester that was served.
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          ptr_d        = (resp_id_q == LAST_ID) ? '0 : resp_id_q + 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_cmd_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_cmd_q    <= add_cmd_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign add_number1 = add_a_q;
  assign add_number2 = add_b_q;
  assign add_command = add_cmd_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_id     = resp_id_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: a latency-accurate adder stand-in, a timestamp-based
// transaction model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_fp_add_arbiter;

  localparam int N    = 4;
  localparam int L    = 2;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [32*N-1:0]   req_a;
  logic [32*N-1:0]   req_b;
  logic [N-1:0]      req_cmd;
  logic [31:0]       add_number1;
  logic [31:0]       add_number2;
  logic              add_command;
  logic              add_sum1;
  logic [7:0]        add_sum2;
  logic [22:0]       add_sum3;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic [IDW-1:0]    resp_id;
  logic              busy;

  always #5 clk = ~clk;

  fp_add_arbiter #(.NUM_REQ(N), .ADD_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
    .add_number1(add_number1), .add_number2(add_number2), .add_command(add_command),
    .add_sum1(add_sum1), .add_sum2(add_sum2), .add_sum3(add_sum3),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Exact IEEE single arithmetic for integer-valued operands.
  function automatic int f2i(input logic [31:0] f);
    int e;
    int m;
    int v;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    if (e < 0) return 0;
    m = int'({1'b1, f[22:0]});
    v = (e >= 23) ? (m <<< (e - 23)) : (m >>> (23 - e));
    return f[31] ? -v : v;
  endfunction

  function automatic logic [31:0] i2f(input int r);
    int mag;
    int p;
    logic [31:0] res;
    if (r == 0) return 32'h0;
    mag = (r < 0) ? -r : r;
    p = 0;
    for (int i = 0; i < 31; i++) if (mag[i]) p = i;
    res[31]    = (r < 0);
    res[30:23] = 8'(127 + p);
    res[22:0]  = (p >= 23) ? 23'(mag >>> (p - 23)) : 23'(mag <<< (23 - p));
    return res;
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic cmd);
    return i2f(cmd ? f2i(a) + f2i(b) : f2i(a) - f2i(b));
  endfunction

  // Adder stand-in: the sum is only correct once its inputs have been stable long enough.
  logic [31:0] prev_n1 = 32'h0;
  logic [31:0] prev_n2 = 32'h0;
  logic        prev_cmd = 1'b0;
  int          age = 0;

  always @(negedge clk) begin
    if (add_number1 !== prev_n1 || add_number2 !== prev_n2 || add_command !== prev_cmd) begin
      age = 0;
    end else if (age < 1000) begin
      age++;
    end
    prev_n1  = add_number1;
    prev_n2  = add_number2;
    prev_cmd = add_command;
  end

  assign {add_sum1, add_sum2, add_sum3} = (age >= L - 1) ? fadd(add_number1, add_number2, add_command)
                                                         : ~fadd(add_number1, add_number2, add_command);

  // Transaction model: an operation accepted in cycle c answers from cycle c+L+1 until consumed.
  bit          model_live = 1'b0;
  bit          m_pending = 1'b0;
  int          m_ptr = 0;
  int          m_id = 0;
  int          m_cycle = 0;
  int          m_acc_cycle = 0;
  int          m_idx;
  logic [31:0] m_a = 32'h0;
  logic [31:0] m_b = 32'h0;
  logic        m_cmd = 1'b0;
  logic [N-1:0] exp_ready;
  bit          exp_rv;
  logic [N-1:0] acc_mask = '0;

  always @(negedge clk) begin
    acc_mask = req_ready;
    if (model_live) begin
      exp_ready = '0;
      if (!m_pending && rst_n) begin
        for (int k = 0; k < N; k++) begin
          m_idx = (m_ptr + k) % N;
          if (exp_ready == '0 && req_valid[m_idx]) exp_ready[m_idx] = 1'b1;
        end
      end
      exp_rv = m_pending && (m_cycle >= m_acc_cycle + L + 1);
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("busy", 32'(busy), 32'(m_pending));
      checkOutput("resp_valid", 32'(resp_valid), 32'(exp_rv));
      checkOutput("add_number1", add_number1, m_a);
      checkOutput("add_number2", add_number2, m_b);
      checkOutput("add_command", 32'(add_command), 32'(m_cmd));
      if (exp_rv) begin
        checkOutput("resp_data", resp_data, fadd(m_a, m_b, m_cmd));
        checkOutput("resp_id", 32'(resp_id), 32'(m_id));
      end
      if (!rst_n) begin
        m_pending = 1'b0;
        m_ptr = 0;
        m_a = 32'h0;
        m_b = 32'h0;
        m_cmd = 1'b0;
      end else if (exp_ready != '0) begin
        for (int k = 0; k < N; k++) if (exp_ready[k]) m_id = k;
        m_pending   = 1'b1;
        m_acc_cycle = m_cycle;
        m_a   = req_a[32*m_id +: 32];
        m_b   = req_b[32*m_id +: 32];
        m_cmd = req_cmd[m_id];
      end else if (exp_rv && resp_ready) begin
        m_pending = 1'b0;
        m_ptr = (m_id + 1) % N;
      end
      m_cycle++;
    end
  end

  // Requester-side stimulus state.
  bit          va[N];
  logic [31:0] op_a[N];
  logic [31:0] op_b[N];
  logic        op_c[N];
  bit          rand_mode = 1'b0;
  int          grants[$];

  task automatic drive_ports();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = va[i];
      req_a[32*i +: 32]   = op_a[i];
      req_b[32*i +: 32]   = op_b[i];
      req_cmd[i]          = op_c[i];
    end
  endtask

  task automatic new_op(input int i);
    va[i]   = 1'b1;
    op_a[i] = i2f(int'($urandom_range(0, 1000)) - 500);
    op_b[i] = i2f(int'($urandom_range(0, 1000)) - 500);
    op_c[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic random_stim();
    if (!rst_n) rst_n = 1'b1;
    else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
    resp_ready = ($urandom_range(0, 9) < 7);
    for (int i = 0; i < N; i++) begin
      if (!va[i]) begin
        if ($urandom_range(0, 3) == 0) new_op(i);
      end else if ($urandom_range(0, 29) == 0) begin
        va[i] = 1'b0;
      end
    end
  endtask

  // Advance one clock; accepted requesters withdraw, then new inputs settle just after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i]) begin
        va[i] = 1'b0;
        grants.push_back(i);
      end
    end
    if (rand_mode) random_stim();
    drive_ports();
  endtask

  task automatic wait_resp(input int budget);
    int n = 0;
    while (!resp_valid && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("resp_arrival", 32'(resp_valid), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) va[i] = 1'b0;
    drive_ports();
    while (busy && n < 50) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) va[i] = 1'b0;
    drive_ports();
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] held_data;
    logic [IDW-1:0] held_id;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    for (int i = 0; i < N; i++) begin
      va[i] = 1'b0;
      op_a[i] = 32'h0;
      op_b[i] = 32'h0;
      op_c[i] = 1'b0;
    end
    do_reset();
    model_live = 1'b1;
    $display("[TB] reset state");
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_data", resp_data, 32'd0);
    checkOutput("rst_resp_id", 32'(resp_id), 32'd0);
    checkOutput("rst_add_number1", add_number1, 32'd0);
    checkOutput("rst_add_number2", add_number2, 32'd0);
    checkOutput("rst_add_command", 32'(add_command), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    $display("[TB] single add");
    va[0] = 1'b1; op_a[0] = 32'h3F800000; op_b[0] = 32'h40000000; op_c[0] = 1'b1;
    drive_ports();
    #1 checkOutput("t1_ready", 32'(req_ready), 32'b0001);
    applyStimulus();
    checkOutput("t1_number1", add_number1, 32'h3F800000);
    checkOutput("t1_number2", add_number2, 32'h40000000);
    checkOutput("t1_command", 32'(add_command), 32'd1);
    checkOutput("t1_ready_pulse", 32'(req_ready), 32'd0);
    checkOutput("t1_valid_early1", 32'(resp_valid), 32'd0);
    applyStimulus();
    checkOutput("t1_valid_early2", 32'(resp_valid), 32'd0);
    applyStimulus();
    checkOutput("t1_valid", 32'(resp_valid), 32'd1);
    checkOutput("t1_data", resp_data, 32'h40400000);
    checkOutput("t1_id", 32'(resp_id), 32'd0);
    applyStimulus();
    checkOutput("t1_valid_drop", 32'(resp_valid), 32'd0);

    $display("[TB] subtract pass-through");
    va[2] = 1'b1; op_a[2] = 32'h3F8E17C2; op_b[2] = 32'h3F8E17C2; op_c[2] = 1'b0;
    drive_ports();
    #1 checkOutput("t2_ready", 32'(req_ready), 32'b0100);
    applyStimulus();
    checkOutput("t2_command", 32'(add_command), 32'd0);
    wait_resp(10);
    checkOutput("t2_data", resp_data, 32'h0);
    checkOutput("t2_id", 32'(resp_id), 32'd2);
    applyStimulus();

    $display("[TB] round-robin");
    do_reset();
    grants.delete();
    for (int n = 0; n < 100 && grants.size() < 5; n++) begin
      for (int i = 0; i < N; i++) if (!va[i]) new_op(i);
      drive_ports();
      applyStimulus();
    end
    checkOutput("rr_count", 32'(grants.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < grants.size(); k++) begin
      checkOutput($sformatf("rr_grant%0d", k), 32'(grants[k]), 32'(exp_order[k]));
    end

    $display("[TB] backpressure");
    for (int i = 0; i < N; i++) if (!va[i]) new_op(i);
    resp_ready = 1'b0;
    drive_ports();
    wait_resp(20);
    held_data = resp_data;
    held_id = resp_id;
    repeat (5) begin
      applyStimulus();
      checkOutput("bp_valid", 32'(resp_valid), 32'd1);
      checkOutput("bp_data", resp_data, held_data);
      checkOutput("bp_id", 32'(resp_id), 32'(held_id));
      checkOutput("bp_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    applyStimulus();
    checkOutput("bp_release", 32'(resp_valid), 32'd0);
    checkOutput("bp_next_grant", 32'(req_ready), 32'(4'b0001 << ((int'(held_id) + 1) % N)));

    $display("[TB] reset mid-wait");
    drain();
    va[1] = 1'b1; op_a[1] = i2f(7); op_b[1] = i2f(5); op_c[1] = 1'b1;
    drive_ports();
    applyStimulus();
    checkOutput("t4_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    applyStimulus();
    checkOutput("t4_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("t4_busy_rst", 32'(busy), 32'd0);
    checkOutput("t4_number1", add_number1, 32'd0);
    checkOutput("t4_resp_id", 32'(resp_id), 32'd0);
    rst_n = 1'b1;
    repeat (4) begin
      applyStimulus();
      checkOutput("t4_no_resp", 32'(resp_valid), 32'd0);
    end
    new_op(0);
    new_op(1);
    drive_ports();
    #1 checkOutput("t4_ptr_zero", 32'(req_ready), 32'b0001);

    $display("[TB] sparse requests");
    drain();
    do_reset();
    new_op(3);
    drive_ports();
    #1 checkOutput("t5_grant3", 32'(req_ready), 32'b1000);
    wait_resp(10);
    applyStimulus();
    new_op(1);
    drive_ports();
    #1 checkOutput("t5_grant1", 32'(req_ready), 32'b0010);
    wait_resp(10);
    applyStimulus();
    new_op(1);
    new_op(2);
    drive_ports();
    #1 checkOutput("t5_ptr_two", 32'(req_ready), 32'b0100);
    drain();

    $display("[TB] random traffic");
    rand_mode = 1'b1;
    repeat (3000) applyStimulus();
    rand_mode = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Shares one IEEE-754 single-precision adder among NUM_REQ requesters.
- Each requester presents two operands plus an add/subtract command using a valid/ready handshake.
- The block selects requests round-robin and drives the adder's number1/number2/command inputs.
- It waits a fixed ADD_LATENCY, captures the adder's {sum1,sum2,sum3} result, and returns it tagged with the requester index.
- It sits between client datapaths and the adder; only one operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADD_LATENCY, 2, clock cycles from the adder inputs becoming stable to a valid adder result (>=1).
- ID_W, $clog2(NUM_REQ), width of the requester index (derived; do not override).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  32*NUM_REQ  operand A, requester i at bits [32i+31:32i]
- req_b  in  32*NUM_REQ  operand B, same packing
- req_cmd  in  NUM_REQ  1=add, 0=subtract, per requester
- add_number1  out  32  to adder number1
- add_number2  out  32  to adder number2
- add_command  out  1  to adder command
- add_sum1  in  1  adder result sign
- add_sum2  in  8  adder result exponent
- add_sum3  in  23  adder result mantissa
- resp_valid  out  1  result valid
- resp_ready  in  1  result consumer ready
- resp_data  out  32  {sum1,sum2,sum3} captured result
- resp_id  out  ID_W  index of the requester that owns resp_data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values:
  - req_ready=0, resp_valid=0, resp_data=0, resp_id=0.
  - add_number1=0, add_number2=0, add_command=0.
  - busy=0, state=IDLE, round-robin pointer=0, latency counter=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant g is the first index with req_valid set, searching from pointer upward with wrap at NUM_REQ-1 to 0.
  - req_ready[g]=1 combinationally, and only while in IDLE with at least one valid request; all other bits are 0.
  - On that edge: latch req_a[g]/req_b[g]/req_cmd[g] into the add_* output registers, latch g as resp_id, load counter=ADD_LATENCY-1, go to WAIT.
  - With no valid request, remain in IDLE.
- WAIT:
  - add_* outputs are held constant.
  - The counter decrements each cycle.
  - On the edge where counter==0: capture resp_data={add_sum1,add_sum2,add_sum3}, set resp_valid=1, go to RESP.
  - Latency: resp_valid rises exactly ADD_LATENCY cycles after the accept edge.
- RESP:
  - resp_valid, resp_data and resp_id are held until resp_valid&&resp_ready.
  - On that edge: resp_valid=0, pointer=(resp_id+1) mod NUM_REQ, go to IDLE.
  - A new grant happens no earlier than the following cycle.
  - Maximum throughput is one operation per ADD_LATENCY+2 cycles.
- Requester rules:
  - A requester must hold req_valid, operands and cmd stable until it sees req_ready.
  - Dropping req_valid before the grant is legal; that requester is simply not selected.
- Fairness: a requester that keeps req_valid asserted is granted within NUM_REQ operations.
- Operand pass-through: operands and cmd pass to the adder unmodified. The block performs no IEEE arithmetic and no NaN/denormal handling.
- Simultaneous events: a request arriving while the block is in WAIT or RESP is not accepted; req_ready stays 0.
- Reset mid-operation: an in-flight operation is discarded with no response, and all state returns to reset values on the next edge.
- resp_ready held at 1 in RESP: response lasts exactly one cycle.

Test Plan:
- Single add: requester 0, a=0x3F800000, b=0x40000000, cmd=1, ADD_LATENCY=2. Required: req_ready[0] pulses 1 cycle; add_number1/2 show the operands the next cycle; resp_valid 2 cycles after the accept edge with resp_data=0x40400000, resp_id=0.
- Round-robin: all 4 requesters valid continuously from reset. Required: grant order 0,1,2,3,0; each resp_id matches; no requester is granted twice before all others are served.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP. Required: resp_valid/resp_data/resp_id stay stable; no req_ready asserted; one cycle after resp_ready=1, return to IDLE and grant the next requester.
- Subtract pass-through: requester 2, a=0x3F8E17C2, b=0x3F8E17C2, cmd=0. Required: add_command=0 during WAIT; resp_data equals the adder output captured at the counter-0 edge, expected 0x00000000.
- Reset mid-WAIT: accept a request on requester 1, drop rst_n one cycle later. Required: no resp_valid ever for that request; all outputs 0; pointer=0, so a later request on requesters 0 and 1 grants 0 first.
- Sparse requests: only requester 3 valid, then only requester 1. Required: each granted on the first IDLE cycle; pointer becomes 0, then 2.
